// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and limits for the PIC program sequencer
package pic_pkg;

   localparam int PC_W_MAX      = 12;
   localparam int STK_DEPTH_MAX = 8;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_SLEEP = 2'd2
   } seq_state_t;

endpackage

// File: rtl/pic_hw_stack.sv
// rtl/pic_hw_stack.sv - generic-depth hardware call/return stack with sticky fault flags
module pic_hw_stack
   import pic_pkg::*;
#(
   parameter int              W         = 9,
   parameter int              DEPTH     = 2,
   parameter int              SAT       = 0,
   parameter logic [W-1:0]    EMPTY_VAL = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic [3:0]   o_lvl,
   output logic         o_ovf,
   output logic         o_unf
);

   localparam logic [2:0] LAST     = 3'(DEPTH - 1);
   localparam logic [3:0] FULL_LVL = 4'(DEPTH);

   // Storage is sized to the maximum so a 3-bit pointer indexes it cleanly at any depth.
   logic [W-1:0] r_mem [STK_DEPTH_MAX];
   logic [2:0]   r_ptr;
   logic [3:0]   r_lvl;
   logic         r_ovf;
   logic         r_unf;

   logic       w_full;
   logic       w_empty;
   logic [2:0] w_ptr_inc;
   logic [2:0] w_ptr_dec;
   logic       w_wr;
   logic       w_pop_mv;

   assign w_full    = (r_lvl == FULL_LVL);
   assign w_empty   = (r_lvl == 4'd0);
   assign w_ptr_inc = (r_ptr == LAST)  ? 3'd0 : r_ptr + 3'd1;
   assign w_ptr_dec = (r_ptr == 3'd0)  ? LAST : r_ptr - 3'd1;
   assign w_wr      = i_push && !((SAT != 0) && w_full);
   assign w_pop_mv  = i_pop && !i_push && !((SAT != 0) && w_empty);

   assign o_data = ((SAT != 0) && w_empty) ? EMPTY_VAL : r_mem[w_ptr_dec];
   assign o_lvl  = r_lvl;
   assign o_ovf  = r_ovf;
   assign o_unf  = r_unf;

   always_ff @(posedge clk) begin
      if (rst && w_wr) begin
         r_mem[r_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= 3'd0;
         r_lvl <= 4'd0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else if (i_push) begin
         if (w_full) r_ovf <= 1'b1;
         if (w_wr) r_ptr <= w_ptr_inc;
         if (!w_full) r_lvl <= r_lvl + 4'd1;
      end else if (i_pop) begin
         if (w_empty) r_unf <= 1'b1;
         if (w_pop_mv) r_ptr <= w_ptr_dec;
         if (!w_empty) r_lvl <= r_lvl - 4'd1;
      end
   end

endmodule

// File: rtl/pic_seq_stack.sv
// rtl/pic_seq_stack.sv - PIC program counter, branch flush, sleep FSM and call stack
module pic_seq_stack
   import pic_pkg::*;
#(
   parameter int              PC_W      = 9,
   parameter int              STK_DEPTH = 2,
   parameter int              STK_SAT   = 0,
   parameter logic [PC_W-1:0] RST_VEC   = {PC_W{1'b1}}
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cyc_en,
   input  logic            goto_i,
   input  logic            call_i,
   input  logic            retlw_i,
   input  logic            pcl_wr_i,
   input  logic            skip_i,
   input  logic            sleep_i,
   input  logic            wake_i,
   input  logic [8:0]      k_i,
   input  logic [7:0]      pcl_i,
   input  logic [2:0]      pa_i,
   output logic [PC_W-1:0] pc_o,
   output logic [PC_W-1:0] pc_next_o,
   output logic            flush_o,
   output logic [3:0]      stk_lvl_o,
   output logic            stk_ovf_o,
   output logic            stk_unf_o,
   output logic            asleep_o
);

   seq_state_t      r_state;
   seq_state_t      w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_next;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_pop_data;
   logic            w_pc_load;
   logic            w_push;
   logic            w_pop;

   // Targets are built at full width with page bits on top, then cut to PC_W.
   logic [PC_W_MAX-1:0] w_goto_full;
   logic [PC_W_MAX-1:0] w_call_full;
   logic [PC_W_MAX-1:0] w_pcl_full;
   logic                w_unused;

   assign w_goto_full = {pa_i, k_i};
   assign w_call_full = {pa_i, 1'b0, k_i[7:0]};
   assign w_pcl_full  = {pa_i, 1'b0, pcl_i};
   assign w_unused    = ^{w_goto_full, w_call_full, w_pcl_full};
   assign w_pc_inc    = r_pc + PC_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_next   = w_pc_inc;
      w_pc_load   = 1'b1;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (goto_i) begin
               w_pc_next   = w_goto_full[PC_W-1:0];
               w_state_nxt = ST_FLUSH;
            end else if (call_i) begin
               w_push      = 1'b1;
               w_pc_next   = w_call_full[PC_W-1:0];
               w_state_nxt = ST_FLUSH;
            end else if (retlw_i) begin
               w_pop       = 1'b1;
               w_pc_next   = w_pop_data;
               w_state_nxt = ST_FLUSH;
            end else if (pcl_wr_i) begin
               w_pc_next   = w_pcl_full[PC_W-1:0];
               w_state_nxt = ST_FLUSH;
            end else if (skip_i) begin
               w_state_nxt = ST_FLUSH;
            end else if (sleep_i) begin
               // PC stays on the SLEEP word; pc+1 is presented and executed on wake.
               w_pc_load   = 1'b0;
               w_state_nxt = ST_SLEEP;
            end
         end
         ST_FLUSH: begin
            w_state_nxt = ST_RUN;
         end
         ST_SLEEP: begin
            w_pc_load = wake_i;
            if (wake_i) w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_RUN;
         r_pc    <= RST_VEC;
      end else if (cyc_en) begin
         r_state <= w_state_nxt;
         if (w_pc_load) r_pc <= w_pc_next;
      end
   end

   pic_hw_stack #(
      .W         (PC_W),
      .DEPTH     (STK_DEPTH),
      .SAT       (STK_SAT),
      .EMPTY_VAL (RST_VEC)
   ) u_stack (
      .clk    (clk),
      .rst    (rst),
      .i_push (w_push && cyc_en),
      .i_pop  (w_pop && cyc_en),
      .i_data (w_pc_inc),
      .o_data (w_pop_data),
      .o_lvl  (stk_lvl_o),
      .o_ovf  (stk_ovf_o),
      .o_unf  (stk_unf_o)
   );

   assign pc_o      = r_pc;
   assign pc_next_o = w_pc_next;
   assign flush_o   = (r_state == ST_FLUSH);
   assign asleep_o  = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_pic_seq_stack.sv
// tb/tb_pic_seq_stack.sv - directed checks of pic_seq_stack in circular, saturating and 11-bit builds
module tb_pic_seq_stack;

   logic       clk = 1'b0;
   logic       rst, cyc_en, goto_i, call_i, retlw_i, pcl_wr_i, skip_i, sleep_i, wake_i;
   logic [8:0] k_i;
   logic [7:0] pcl_i;
   logic [2:0] pa_i;

   logic [8:0]  pc_c, pcn_c, pc_s, pcn_s;
   logic [10:0] pc_w, pcn_w;
   logic [3:0]  lvl_c, lvl_s, lvl_w;
   logic        fl_c, fl_s, fl_w, ovf_c, ovf_s, ovf_w, unf_c, unf_s, unf_w, sl_c, sl_s, sl_w;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pic_seq_stack #(.PC_W(9), .STK_DEPTH(2), .STK_SAT(0)) u9c (
      .clk(clk), .rst(rst), .cyc_en(cyc_en), .goto_i(goto_i), .call_i(call_i), .retlw_i(retlw_i),
      .pcl_wr_i(pcl_wr_i), .skip_i(skip_i), .sleep_i(sleep_i), .wake_i(wake_i), .k_i(k_i),
      .pcl_i(pcl_i), .pa_i(pa_i), .pc_o(pc_c), .pc_next_o(pcn_c), .flush_o(fl_c),
      .stk_lvl_o(lvl_c), .stk_ovf_o(ovf_c), .stk_unf_o(unf_c), .asleep_o(sl_c));

   pic_seq_stack #(.PC_W(9), .STK_DEPTH(2), .STK_SAT(1)) u9s (
      .clk(clk), .rst(rst), .cyc_en(cyc_en), .goto_i(goto_i), .call_i(call_i), .retlw_i(retlw_i),
      .pcl_wr_i(pcl_wr_i), .skip_i(skip_i), .sleep_i(sleep_i), .wake_i(wake_i), .k_i(k_i),
      .pcl_i(pcl_i), .pa_i(pa_i), .pc_o(pc_s), .pc_next_o(pcn_s), .flush_o(fl_s),
      .stk_lvl_o(lvl_s), .stk_ovf_o(ovf_s), .stk_unf_o(unf_s), .asleep_o(sl_s));

   pic_seq_stack #(.PC_W(11), .STK_DEPTH(2), .STK_SAT(0)) u11 (
      .clk(clk), .rst(rst), .cyc_en(cyc_en), .goto_i(goto_i), .call_i(call_i), .retlw_i(retlw_i),
      .pcl_wr_i(pcl_wr_i), .skip_i(skip_i), .sleep_i(sleep_i), .wake_i(wake_i), .k_i(k_i),
      .pcl_i(pcl_i), .pa_i(pa_i), .pc_o(pc_w), .pc_next_o(pcn_w), .flush_o(fl_w),
      .stk_lvl_o(lvl_w), .stk_ovf_o(ovf_w), .stk_unf_o(unf_w), .asleep_o(sl_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      goto_i = 0; call_i = 0; retlw_i = 0; pcl_wr_i = 0; skip_i = 0; sleep_i = 0; wake_i = 0;
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      cyc_en = 1; k_i = 0; pcl_i = 0; pa_i = 0;
      do_reset();
      #1;
      chk("rst_pc",     pc_c, 32'h1FF);
      chk("rst_pcnext", pcn_c, 32'h000);
      chk("rst_lvl",    lvl_c, 0);
      chk("rst_ovf",    ovf_c, 0);
      chk("rst_unf",    unf_c, 0);
      chk("rst_flush",  fl_c, 0);
      chk("rst_asleep", sl_c, 0);
      chk("rst_pc11",   pc_w, 32'h7FF);

      // Reach pc=0x010 via GOTO 0x00F plus its flush cycle
      goto_i = 1; k_i = 9'h00F; #1;
      chk("goto_pcnext", pcn_c, 32'h00F);
      tick(); clr();
      chk("goto_flush", fl_c, 1);
      tick();
      chk("goto_pc", pc_c, 32'h010);
      chk("goto_noflush", fl_c, 0);

      call_i = 1; k_i = 9'h0A5; #1;
      chk("call_pcnext", pcn_c, 32'h0A5);
      tick(); clr();
      chk("call_flush", fl_c, 1);
      chk("call_lvl", lvl_c, 1);
      chk("call_pc", pc_c, 32'h0A5);
      tick();
      retlw_i = 1; #1;
      chk("ret_pcnext", pcn_c, 32'h011);
      tick(); clr();
      chk("ret_lvl", lvl_c, 0);
      chk("ret_flush", fl_c, 1);
      tick();

      // Three nested calls on a depth-2 stack; return addresses 0x013, 0x042, 0x052
      call_i = 1; k_i = 9'h040; tick(); clr(); tick();
      call_i = 1; k_i = 9'h050; tick(); clr(); tick();
      chk("ovf_before", ovf_c, 0);
      call_i = 1; k_i = 9'h060; tick(); clr();
      chk("c_ovf", ovf_c, 1);
      chk("c_lvl2", lvl_c, 2);
      chk("s_ovf", ovf_s, 1);
      chk("s_lvl2", lvl_s, 2);
      tick();
      retlw_i = 1; #1;
      chk("c_pop1", pcn_c, 32'h052);
      chk("s_pop1", pcn_s, 32'h042);
      tick(); clr();
      chk("c_lvl1", lvl_c, 1);
      tick();
      retlw_i = 1; #1;
      chk("c_pop2", pcn_c, 32'h042);
      chk("s_pop2", pcn_s, 32'h013);
      tick(); clr(); tick();
      chk("unf_before", unf_c, 0);
      retlw_i = 1; #1;
      chk("c_pop3", pcn_c, 32'h052);
      chk("s_pop3", pcn_s, 32'h1FF);
      tick(); clr();
      chk("c_unf", unf_c, 1);
      chk("s_unf", unf_s, 1);
      chk("c_lvl0", lvl_c, 0);
      chk("s_lvl0", lvl_s, 0);
      chk("c_ovf_sticky", ovf_c, 1);
      tick();

      // 11-bit build: paged targets, computed goto, wrap on skip
      do_reset();
      chk("rst_clears_ovf", ovf_c, 0);
      pa_i = 3'b010; goto_i = 1; k_i = 9'h1FF; #1;
      chk("w_goto", pcn_w, 32'h5FF);
      tick(); clr();
      chk("w_goto_pc", pc_w, 32'h5FF);
      tick();
      pcl_wr_i = 1; pcl_i = 8'h33; #1;
      chk("w_pcl", pcn_w, 32'h433);
      tick(); clr(); tick();
      pa_i = 3'b011; goto_i = 1; k_i = 9'h1FE; tick(); clr(); tick();
      chk("w_at_max", pc_w, 32'h7FF);
      skip_i = 1; #1;
      chk("w_skip_wrap", pcn_w, 32'h000);
      tick(); clr();
      chk("w_skip_flush", fl_w, 1);
      chk("w_skip_pc", pc_w, 32'h000);
      tick();
      chk("w_flush_end", fl_w, 0);
      chk("w_after", pc_w, 32'h001);
      cyc_en = 0; goto_i = 1; k_i = 9'h100; tick(); clr();
      chk("w_hold", pc_w, 32'h001);
      cyc_en = 1;

      // Sleep at 0x020 with strobes toggling, then wake
      pa_i = 0;
      do_reset();
      goto_i = 1; k_i = 9'h01F; tick(); clr(); tick();
      chk("sl_pc", pc_c, 32'h020);
      sleep_i = 1; tick(); clr();
      chk("sl_asleep", sl_c, 1);
      for (int i = 0; i < 5; i++) begin
         goto_i = i[0]; call_i = ~i[0]; skip_i = 1; k_i = 9'h155;
         tick();
         chk("sl_pc_hold", pc_c, 32'h020);
         chk("sl_pcn_hold", pcn_c, 32'h021);
      end
      clr();
      chk("sl_nopush", lvl_c, 0);
      chk("sl_still", sl_c, 1);
      wake_i = 1; tick(); clr();
      chk("wake_asleep", sl_c, 0);
      chk("wake_pc", pc_c, 32'h021);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
